// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with HI/LO result registers
// One result bit per clock: shift-add multiply, restoring divide, sign fixup in FINISH.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        hi_write,
  input  logic        lo_write,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [33:0] div_trial;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign a_neg = op[0] & a[31];
  assign b_neg = op[0] & b[31];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply keeps the multiplier in acc[31:0]; divide keeps the quotient there.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_trial = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};

  assign prod_fix = neg_q  ? -acc_q          : acc_q;
  assign quot_fix = neg_q  ? -acc_q[31:0]    : acc_q[31:0];
  assign rem_fix  = rneg_q ? -acc_q[63:32]   : acc_q[63:32];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (cnt_q == 6'd1) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          opnd_d   = op[1] ? b_mag : a_mag;
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dz_d     = op[1] & (b == 32'd0);
          cnt_d    = 6'd32;
        end else begin
          if (hi_write) hi_d = a;
          if (lo_write) lo_d = a;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 6'd1;
        if (is_div_q) begin
          acc_d = div_trial[33] ? {acc_q[62:0], 1'b0}
                                : {div_trial[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        if (is_div_q) begin
          // A zero divisor leaves the dividend as remainder; only the quotient is forced.
          hi_d = rem_fix;
          lo_d = dz_q ? 32'hFFFF_FFFF : quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Table of directed vectors plus hand sequences for conflicts, MT writes and reset abort.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [1:0]  op = 2'd0;
  logic        start = 1'b0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .hi_write(hi_write), .lo_write(lo_write), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start edge until done, bounded at 40.
  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (done) break;
      if (busy) bc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n, bc;
    start_op(v.op, v.a, v.b);
    wait_done(n, bc);
    check({tag, "_latency"}, 64'(n), 64'd34);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, v.hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, v.lo});
    @(negedge clock);
    check({tag, "_done_single"}, {63'd0, done}, 64'd0);
    check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n, bc;
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};

    #12;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start/MT writes during RUN are ignored; hi/lo hold the prior result meanwhile.
    start_op(2'b00, 32'd3, 32'd4);
    repeat (5) @(negedge clock);
    check("run_hold_lo", {32'd0, lo}, {32'd0, vecs[7].lo});
    a = 32'h0000_0999; start = 1'b1; hi_write = 1'b1; lo_write = 1'b1;
    @(posedge clock);
    #1 start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    check("run_ignore_hi", {32'd0, hi}, {32'd0, vecs[7].hi});
    wait_done(n, bc);
    check("inject_done_seen", {63'd0, done}, 64'd1);
    check("inject_hi", {32'd0, hi}, 64'd0);
    check("inject_lo", {32'd0, lo}, 64'd12);
    repeat (3) @(negedge clock);
    check("inject_no_restart", {63'd0, busy}, 64'd0);

    @(negedge clock);
    a = 32'hDEAD_BEEF; hi_write = 1'b1;
    @(posedge clock);
    #1 hi_write = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h0000_0000_DEAD_BEEF);
    check("mthi_lo_kept", {32'd0, lo}, 64'd12);

    // Start wins over a simultaneous MTLO.
    @(negedge clock);
    op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1; lo_write = 1'b1;
    @(posedge clock);
    #1 start = 1'b0; lo_write = 1'b0;
    check("conflict_lo_dropped", {32'd0, lo}, 64'd12);
    check("conflict_busy", {63'd0, busy}, 64'd1);
    wait_done(n, bc);
    check("conflict_latency", 64'(n), 64'd34);
    check("conflict_hi", {32'd0, hi}, 64'd0);
    check("conflict_lo", {32'd0, lo}, 64'd42);

    @(negedge clock);
    a = 32'h55; hi_write = 1'b1;
    @(posedge clock);
    #1 hi_write = 1'b0;
    check("mthi55", {32'd0, hi}, 64'h55);
    start_op(2'b10, 32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) n++;
    end
    reset = 1'b1;
    repeat (30) begin
      @(negedge clock);
      if (done) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);
    run_vec('{2'b10, 32'd9, 32'd2, 32'd1, 32'd4}, "post_reset_divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers for the single-cycle processor datapath. It sits directly downstream of the general-purpose register file and consumes the two read ports (rs data, rt data) when a MULT/MULTU/DIV/DIVU instruction issues. It computes one result bit per clock and holds the 64-bit product or quotient/remainder in HI/LO for later MFHI/MFLO reads. MTHI/MTLO writes also load HI/LO directly from the rs read port.

## Interface
Parameters:
- none; the datapath width is fixed at 32 bits.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- a  in  32  operand from the GPR rs read port (multiplicand or dividend; MTHI/MTLO data).
- b  in  32  operand from the GPR rt read port (multiplier or divisor).
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled only with start.
- start  in  1  launches an operation when the unit is idle.
- hi_write  in  1  MTHI: loads hi from a when idle.
- lo_write  in  1  MTLO: loads lo from a when idle.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse on the cycle HI/LO take a new result.
- hi  out  32  HI register: upper product word, or remainder.
- lo  out  32  LO register: lower product word, or quotient.

## Operation
- State machine: IDLE -> RUN -> FINISH -> IDLE.
- IDLE, start=1:
  - Capture |a|, |b|, the result sign and the op into internal registers.
  - Load iteration counter = 32 and go to RUN.
  - For unsigned ops the magnitudes are the raw operand values.
- RUN: one iteration per edge; decrement the counter; go to FINISH after the 32nd iteration.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 64-bit remainder/quotient register.
- FINISH:
  - Apply the sign fixup: for a signed product, negate the 64-bit result if the operand signs differ. For DIV, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
  - Write hi/lo, pulse done, return to IDLE.
- Divide by zero (b=0, DIVU or DIV): lo=0xFFFFFFFF, hi=a (raw bits); normal latency still applies.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000. No trap.
- MULT/MULTU: product is exact to 64 bits; {hi,lo} = full product.
- Register writes in IDLE:
  - hi_write=1 loads hi<=a; lo_write=1 loads lo<=a.
  - Both asserted together load both from a.
- Conflicts and ignored inputs:
  - start and hi_write/lo_write asserted together in IDLE: start wins, and the writes are dropped.
  - start, hi_write and lo_write are all ignored while busy=1, including in FINISH.
- hi/lo hold their previous values throughout RUN and change only in FINISH or on an MT write.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts immediately. hi/lo return to 0 rather than their prior values, and no done pulse is produced.
- Start edge E0: operands are captured and busy goes 1 after E0.
- Edges E1..E32: the 32 iterations.
- Edge E33 (FINISH):
  - hi/lo are updated.
  - done=1 for exactly the cycle after E33.
  - busy=0 after E33.
- A new start is accepted at E34 at the earliest. With start held continuously high, operations run back-to-back every 34 cycles.
- MT writes take effect at the edge where hi_write/lo_write are sampled (1-cycle latency).
- done and busy are registered outputs with no combinational path from inputs.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Check busy for 33 cycles and a single done pulse after E33.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start, hi_write and lo_write pulsed at E5 of a MULTU 3x4 -> ignored, result hi=0, lo=12. Afterwards in IDLE:
  - hi_write with a=0xDEADBEEF -> hi=0xDEADBEEF.
  - start together with lo_write -> the op runs, and lo_write is dropped.
- Reset low at E10 of a DIVU 100/7 that was preceded by MTHI 0x55 -> busy=0, hi=lo=0 immediately and no done pulse. A following DIVU 9/2 -> lo=4, hi=1.
